sdp_fifo_ctrl: RTL

//   Synchronous first-word-fall-through FIFO controller that drives one sdp_ram instance.

---
 rtl/sdp_fifo_ctrl.sv | 101 ++++++++++
 1 files changed

// File: rtl/sdp_fifo_ctrl.sv
// First-word-fall-through FIFO controller driving one sdp_ram.
// A 2-entry skid buffer hides the RAM's registered read latency.
module sdp_fifo_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int DATA_DEPTH = 1024,
  localparam int AW = $clog2(DATA_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [AW+1:0]         level,
  output logic                  ram_wr_en,
  output logic [AW-1:0]         ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic                  ram_rd_en,
  output logic [AW-1:0]         ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data
);

  localparam logic [AW:0] FULL = (AW+1)'(DATA_DEPTH);

  logic [AW:0]           wptr_q, wptr_d;
  logic [AW:0]           rptr_q, rptr_d;
  logic [AW:0]           ram_cnt;
  logic                  inflight_q, inflight_d;
  logic [1:0]            ob_cnt_q, ob_cnt_d;
  logic [1:0]            base;
  logic [DATA_WIDTH-1:0] sk0_q, sk0_d;
  logic [DATA_WIDTH-1:0] sk1_q, sk1_d;
  logic                  push, pop;
  logic [2:0]            occ, lim;

  // Wrap bit in the pointer MSB separates full from empty.
  assign ram_cnt = wptr_q - rptr_q;
  assign s_ready = ~rst & (ram_cnt != FULL);
  assign push    = s_valid & s_ready;
  assign m_valid = (ob_cnt_q != 2'd0);
  assign pop     = m_valid & m_ready;

  // Prefetch only while the skid can absorb the word on return.
  assign occ       = {1'b0, ob_cnt_q} + {2'b0, inflight_q};
  assign lim       = 3'd2 + {2'b0, pop};
  assign ram_rd_en = (ram_cnt != '0) & (occ < lim);

  assign ram_wr_en   = push;
  assign ram_wr_addr = wptr_q[AW-1:0];
  assign ram_wr_data = s_data;
  assign ram_rd_addr = rptr_q[AW-1:0];

  // Head of the skid is a register: no path from ram_rd_data.
  assign m_data = sk0_q;
  assign level  = {1'b0, ram_cnt}
                + (AW+2)'(ob_cnt_q)
                + (AW+2)'(inflight_q);

  // Next-state for pointers, in-flight flag and skid buffer.
  always_comb begin
    wptr_d     = wptr_q + (AW+1)'(push);
    rptr_d     = rptr_q + (AW+1)'(ram_rd_en);
    inflight_d = ram_rd_en;
    base       = ob_cnt_q - {1'b0, pop};
    ob_cnt_d   = base + {1'b0, inflight_q};
    sk0_d      = sk0_q;
    sk1_d      = sk1_q;
    if (pop) begin
      sk0_d = sk1_q;
    end
    if (inflight_q) begin
      if (base == 2'd0) begin
        sk0_d = ram_rd_data;
      end else begin
        sk1_d = ram_rd_data;
      end
    end
  end

  // State registers; a read in flight at reset is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      inflight_q <= 1'b0;
      ob_cnt_q   <= 2'd0;
      sk0_q      <= '0;
      sk1_q      <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      inflight_q <= inflight_d;
      ob_cnt_q   <= ob_cnt_d;
      sk0_q      <= sk0_d;
      sk1_q      <= sk1_d;
    end
  end

endmodule
